data_mem_resp: RTL
==================

# data_mem_resp

Data-memory responder for the RISC-V five-stage pipeline: serves memory-stage load/store requests and produces the load data consumed by the MEM/WB pipeline register. It holds a byte-addressed little-endian RAM and performs byte-lane writes and sign/zero-extended reads. A fixed-latency FSM stalls the pipeline for the duration of each access. Load data is registered and presented during a one-cycle completion window.

## Interface
- DATA_WIDTH, 32, data path width; only 32 is supported.
- ADDR_WIDTH, 17, byte address bits used; RAM is 2^ADDR_WIDTH bytes.
- LATENCY, 2, wait cycles per access; must be >= 1.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- MemReqM  in  1  memory-stage instruction is a load or store.
- MemWriteM  in  1  1 = store, 0 = load; sampled with MemReqM.
- ALUResultM  in  DATA_WIDTH  byte address.
- WriteDataM  in  DATA_WIDTH  store data; the low bytes are used for SB/SH.
- Funct3M  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- RD  out  DATA_WIDTH  extended load data, registered.
- DoneM  out  1  one-cycle completion pulse.
- StallM  out  1  freeze the fetch, decode, execute and memory stages.
- MisalignM  out  1  misaligned-access flag; see Configuration.

## Operation
- States are IDLE, BUSY and DONE.
- IDLE:
  - When MemReqM=1, capture address, data, Funct3M and MemWriteM.
  - Load the counter with LATENCY-1 and go to BUSY.
- BUSY:
  - While the counter is nonzero, decrement it.
  - When the counter is 0, perform the access at the clock edge and go to DONE.
- DONE:
  - DoneM=1 for this cycle; MemReqM is ignored.
  - Return to IDLE.
- StallM is combinational: (IDLE and MemReqM) or BUSY. It is 0 in DONE.
- Stores:
  - SB writes the byte lane selected by addr[1:0].
  - SH writes the half selected by addr[1].
  - SW writes the whole word.
  - RD is unchanged by a store.
- Loads:
  - B and H are sign-extended; BU and HU are zero-extended; W is passed through.
  - The result is written into RD at the access edge.
- Funct3M values 011, 110 and 111 are treated as W.
- Address bits at and above ADDR_WIDTH are ignored, so addresses wrap modulo the RAM size.
- Misaligned accesses are H/HU/SH with addr[0]=1, and W with addr[1:0]≠0. Handling is set by the macro.

## Timing
- Reset values: state IDLE, counter 0, RD=0, DoneM=0, MisalignM=0. StallM is 0 while MemReqM=0.
- RAM contents are not reset.
- For a request first seen in cycle 0:
  - StallM is high in cycles 0..LATENCY.
  - The access is performed at the end of cycle LATENCY.
  - DONE (DoneM=1, RD valid) occurs in cycle LATENCY+1.
- The MEM/WB register latches RD at the end of the DONE cycle.
- The next instruction's request can start in cycle LATENCY+2. Back-to-back accesses cost LATENCY+2 cycles each.
- RD holds its value until the next load's access edge.
- Reset mid-operation returns the FSM to IDLE immediately.
  - A store whose access edge has not yet occurred is not committed.
  - No DoneM pulse is produced for an aborted access.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - A misaligned access performs no RAM read or write, and RD is unchanged.
  - Latency is unchanged.
  - MisalignM=1 during the DONE cycle, coincident with DoneM.
- DMEM_MISALIGN_TRAP_EN undefined:
  - The address is force-aligned: addr[0]=0 for H, addr[1:0]=0 for W.
  - The access proceeds normally.
  - MisalignM is tied to 0.

## Test plan
- SW 0xDEADBEEF to 0x100, then LW 0x100, with LATENCY=2 -> RD=0xDEADBEEF in DONE; StallM high exactly 3 cycles per access; exactly one DoneM pulse each.
- After the store above:
  - LB 0x103 -> 0xFFFFFFDE.
  - LBU 0x103 -> 0x000000DE.
  - LH 0x102 -> 0xFFFFDEAD.
  - LHU 0x102 -> 0x0000DEAD.
- SB 0x55 to 0x101, then LW 0x100 -> 0xDEAD55EF. SH 0xAAAA to 0x102, then LW 0x100 -> 0xAAAA55EF.
- LW 0x102:
  - With the macro: MisalignM=1 with DoneM, RD keeps its prior value, RAM is unchanged.
  - Without the macro: RD returns the word at 0x100.
- SW 0x11111111 to 0x200. Then start SW 0x12345678 to 0x200 and pull rst_n low during BUSY -> StallM=0 and RD=0 immediately; a later LW 0x200 -> 0x11111111.
- LW and SW to address 0x100 + 2^ADDR_WIDTH alias 0x100; MemReqM held high through DONE does not start a second access.

Source files
------------

// File: rtl/data_mem_resp.sv
// data_mem_resp
//   Data-memory responder for the memory stage of a five-stage RISC-V pipeline.
//   Holds a byte-addressed, little-endian RAM of 2^ADDR_WIDTH bytes, organised as
//   32-bit words with byte-lane write enables. Every access takes a fixed
//   LATENCY wait cycles, during which StallM freezes the upstream stages. A
//   one-cycle DONE window follows, where DoneM pulses and RD carries the load
//   result.
//
//   Handshake: a request is accepted in IDLE whenever MemReqM=1. The request
//   fields are captured on that edge. StallM stays high until the access edge.
//   DoneM=1 for exactly one cycle afterwards, and MemReqM is ignored in that
//   cycle. The next request can be accepted in the cycle after DONE.
//
//   Configuration macro: DMEM_MISALIGN_TRAP_EN
//     defined   - a misaligned access does not touch RAM or RD; MisalignM=1 with DoneM
//     undefined - misaligned addresses are force-aligned; MisalignM is always 0
//
//   Ports
//     clk, rst_n   clock, asynchronous active-low reset
//     MemReqM      load/store request from the memory stage
//     MemWriteM    1 = store, 0 = load
//     ALUResultM   byte address (bits at and above ADDR_WIDTH ignored)
//     WriteDataM   store data (low bytes used for SB/SH)
//     Funct3M      000 B, 001 H, 010 W, 100 BU, 101 HU (011/110/111 act as W)
//     RD           registered, extended load data
//     DoneM        one-cycle completion pulse
//     StallM       pipeline freeze: (IDLE and MemReqM) or BUSY
//     MisalignM    misaligned-access flag, valid with DoneM
module data_mem_resp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemReqM,
    input  logic                  MemWriteM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [2:0]            Funct3M,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  DoneM,
    output logic                  StallM,
    output logic                  MisalignM
);

    localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
    localparam int CW    = $clog2(LATENCY + 1);

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [2:0]              funct3_q;
    logic                    write_q;
    logic                    mis_q;

    logic [DATA_WIDTH-1:0]   mem [WORDS];

    logic                    is_byte;
    logic                    is_half;
    logic                    is_word;
    logic                    misalign;
    logic [ADDR_WIDTH-1:0]   eff_addr;
    logic [ADDR_WIDTH-3:0]   word_idx;
    logic [1:0]              lane;
    logic                    access_edge;
    logic                    access_ok;
    logic                    ram_we;
    logic [3:0]              be;
    logic [DATA_WIDTH-1:0]   wlane;
    logic [DATA_WIDTH-1:0]   rword;
    logic [DATA_WIDTH-1:0]   shifted;
    logic [7:0]              byte_v;
    logic [15:0]             half_v;
    logic [DATA_WIDTH-1:0]   load_data;
    logic                    unused_addr_hi;

    // Address bits above the RAM size simply alias.
    assign unused_addr_hi = ^ALUResultM[DATA_WIDTH-1:ADDR_WIDTH];

    // funct3[1:0] decides the size; 011/110/111 fall into the word group.
    assign is_byte  = (funct3_q[1:0] == 2'b00);
    assign is_half  = (funct3_q[1:0] == 2'b01);
    assign is_word  = funct3_q[1];
    assign misalign = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));

`ifdef DMEM_MISALIGN_TRAP_EN
    // Misaligned accesses are suppressed, so the raw address is used as-is.
    assign eff_addr = addr_q;
`else
    always_comb begin
        eff_addr = addr_q;
        if (is_word) begin
            eff_addr[1:0] = 2'b00;
        end else if (is_half) begin
            eff_addr[0] = 1'b0;
        end
    end
`endif

    assign word_idx    = eff_addr[ADDR_WIDTH-1:2];
    assign lane        = eff_addr[1:0];
    assign access_edge = (state == BUSY) && (cnt == '0);
    assign access_ok   = !(TRAP_EN && misalign);
    assign ram_we      = access_edge && write_q && access_ok;

    // Byte enables and lane-replicated write data.
    always_comb begin
        be    = 4'b0000;
        wlane = wdata_q;
        if (is_byte) begin
            be    = 4'b0001 << lane;
            wlane = {4{wdata_q[7:0]}};
        end else if (is_half) begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wlane = {2{wdata_q[15:0]}};
        end else begin
            be    = 4'b1111;
            wlane = wdata_q;
        end
    end

    // Load extraction: funct3[2] selects zero extension.
    always_comb begin
        rword     = mem[word_idx];
        shifted   = rword >> {lane, 3'b000};
        byte_v    = shifted[7:0];
        half_v    = lane[1] ? rword[31:16] : rword[15:0];
        load_data = rword;
        if (is_byte) begin
            load_data = {{24{byte_v[7] & ~funct3_q[2]}}, byte_v};
        end else if (is_half) begin
            load_data = {{16{half_v[15] & ~funct3_q[2]}}, half_v};
        end
    end

    // RAM array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[word_idx][8*b +: 8] <= wlane[8*b +: 8];
                end
            end
        end
    end

    // Control FSM with registered RD / DoneM / MisalignM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            write_q  <= 1'b0;
            RD       <= '0;
            DoneM    <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DoneM <= 1'b0;
                    mis_q <= 1'b0;
                    if (MemReqM) begin
                        addr_q   <= ALUResultM[ADDR_WIDTH-1:0];
                        wdata_q  <= WriteDataM;
                        funct3_q <= Funct3M;
                        write_q  <= MemWriteM;
                        cnt      <= CW'(LATENCY - 1);
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (!write_q && access_ok) begin
                            RD <= load_data;
                        end
                        DoneM <= 1'b1;
                        mis_q <= TRAP_EN && misalign;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // MemReqM is ignored here; a held request does not restart.
                    DoneM <= 1'b0;
                    mis_q <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    DoneM <= 1'b0;
                    mis_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign StallM    = ((state == IDLE) && MemReqM) || (state == BUSY);
    assign MisalignM = mis_q;

endmodule
